// File: rtl/histogram_hesapla.sv
// -----------------------------------------------------------------------------
// histogram_hesapla
//
// Histogram computation stage feeding the histogram-equalization block.
// Streams 8-bit grayscale pixels, accumulates a 256-bin count table in an
// internal synchronous-read memory, then drains the table bin 0..255 as V-bit
// words over a valid/ready handshake. Every start clears the table first, so
// the drained table always matches the frame actually streamed.
//
// Flow: IDLE -> CLEAR (256 cycles) -> ACCUM (PIXELS transfers) -> FLUSH
//       (2 cycles) -> DRAIN (256 words) -> DONE -> CLEAR on basla_i.
//
// Ports:
//   clk_i            in   1  clock, all logic on rising edge
//   rst_i            in   1  asynchronous reset, active low
//   basla_i          in   1  start pulse, honoured only in IDLE or DONE
//   veri_i           in   8  pixel value (bin index)
//   veri_gecerli_i   in   1  pixel valid
//   veri_al_o        out  1  ready to accept a pixel (high in ACCUM)
//   veri_histogram_o out  V  bin count being offered
//   adres_o          out  8  bin index of veri_histogram_o
//   veri_gonder_o    out  1  output word valid
//   veri_alindi_i    in   1  consumer ready
//   islem_bitti_o    out  1  frame complete, table fully drained
// -----------------------------------------------------------------------------
module histogram_hesapla #(
    parameter int unsigned PIXELS = 76800,
    parameter int unsigned V      = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         basla_i,
    input  logic [7:0]   veri_i,
    input  logic         veri_gecerli_i,
    output logic         veri_al_o,
    output logic [V-1:0] veri_histogram_o,
    output logic [7:0]   adres_o,
    output logic         veri_gonder_o,
    input  logic         veri_alindi_i,
    output logic         islem_bitti_o
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_ACCUM = 3'd2;
    localparam logic [2:0] S_FLUSH = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [V-1:0] LAST_PIX = V'(PIXELS - 1);
    localparam logic [V-1:0] CNT_MAX  = {V{1'b1}};
    localparam logic [V-1:0] CNT_ONE  = V'(1);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [2:0]   state_q,     state_d;
    logic [7:0]   bin_idx_q,   bin_idx_d;    // clear address, then drain address
    logic [V-1:0] pix_cnt_q,   pix_cnt_d;    // accepted pixels this frame
    logic         flush_q,     flush_d;      // second FLUSH cycle marker
    logic         s2_valid_q,  s2_valid_d;   // write stage holds a pixel
    logic [7:0]   s2_addr_q,   s2_addr_d;    // bin being written this cycle
    logic         fwd_hit_q,   fwd_hit_d;    // read collided with a write
    logic [V-1:0] fwd_val_q,   fwd_val_d;    // value written during that collision

    // -------------------------------------------------------------------------
    // Count table memory: one write port, one synchronous read port
    // -------------------------------------------------------------------------
    logic [V-1:0] mem [0:255];
    logic [V-1:0] rd_data_q;
    logic         mem_we;
    logic [7:0]   mem_waddr;
    logic [V-1:0] mem_wdata;
    logic         mem_re;
    logic [7:0]   mem_raddr;

    logic         pix_xfer;
    logic         out_xfer;
    logic [V-1:0] acc_base;
    logic [V-1:0] acc_next;

    assign pix_xfer = (state_q == S_ACCUM) && veri_gecerli_i;
    assign out_xfer = (state_q == S_DRAIN) && veri_alindi_i;

    // The memory returned the value from before the same-cycle write when the
    // previous read hit the bin being written; take the written value instead.
    assign acc_base = fwd_hit_q ? fwd_val_q : rd_data_q;
    assign acc_next = (acc_base == CNT_MAX) ? acc_base : acc_base + CNT_ONE;

    // -------------------------------------------------------------------------
    // Memory port steering
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default at the top of a combinational
        // block, so no path leaves it unassigned and no latch is inferred.
        mem_we    = 1'b0;
        mem_waddr = s2_addr_q;
        mem_wdata = acc_next;
        mem_re    = 1'b0;
        mem_raddr = veri_i;

        if (state_q == S_CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = bin_idx_q;
            mem_wdata = '0;
        end else if (s2_valid_q) begin
            mem_we    = 1'b1;
        end

        case (state_q)
            S_ACCUM: begin
                mem_re    = pix_xfer;
                mem_raddr = veri_i;
            end
            S_FLUSH: begin
                // The last accumulate write has committed by the second FLUSH
                // cycle, so bin 0 can be prefetched for DRAIN here.
                mem_re    = flush_q;
                mem_raddr = 8'd0;
            end
            S_DRAIN: begin
                // Advance only on a transfer; while stalled the read register
                // keeps the offered word stable.
                mem_re    = out_xfer;
                mem_raddr = bin_idx_q + 8'd1;
            end
            default: begin
                mem_re    = 1'b0;
            end
        endcase
    end

    // NOTE: the table itself has no reset; every start rewrites all 256 bins
    // in CLEAR, and a resettable array would not map onto block RAM.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
        if (mem_re) begin
            rd_data_q <= mem[mem_raddr];
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        bin_idx_d  = bin_idx_q;
        pix_cnt_d  = pix_cnt_q;
        flush_d    = flush_q;

        // Accumulate pipeline: read issued in the accept cycle, write one
        // cycle later.
        s2_valid_d = pix_xfer;
        s2_addr_d  = veri_i;
        fwd_hit_d  = pix_xfer && s2_valid_q && (veri_i == s2_addr_q);
        fwd_val_d  = acc_next;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (basla_i) begin
                    state_d   = S_CLEAR;
                    bin_idx_d = 8'd0;
                    pix_cnt_d = '0;
                    flush_d   = 1'b0;
                end
            end

            S_CLEAR: begin
                // Wraps 255 -> 0, leaving the index ready for the next use.
                bin_idx_d = bin_idx_q + 8'd1;
                if (bin_idx_q == 8'hFF) begin
                    state_d = S_ACCUM;
                end
            end

            S_ACCUM: begin
                if (pix_xfer) begin
                    pix_cnt_d = pix_cnt_q + CNT_ONE;
                    if (pix_cnt_q == LAST_PIX) begin
                        state_d = S_FLUSH;
                        flush_d = 1'b0;
                    end
                end
            end

            S_FLUSH: begin
                flush_d = 1'b1;
                if (flush_q) begin
                    state_d   = S_DRAIN;
                    bin_idx_d = 8'd0;
                end
            end

            S_DRAIN: begin
                if (out_xfer) begin
                    bin_idx_d = bin_idx_q + 8'd1;
                    if (bin_idx_q == 8'hFF) begin
                        state_d = S_DONE;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Control registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge values regardless of statement order.
            state_q    <= S_IDLE;
            bin_idx_q  <= 8'd0;
            pix_cnt_q  <= '0;
            flush_q    <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_addr_q  <= 8'd0;
            fwd_hit_q  <= 1'b0;
            fwd_val_q  <= '0;
        end else begin
            state_q    <= state_d;
            bin_idx_q  <= bin_idx_d;
            pix_cnt_q  <= pix_cnt_d;
            flush_q    <= flush_d;
            s2_valid_q <= s2_valid_d;
            s2_addr_q  <= s2_addr_d;
            fwd_hit_q  <= fwd_hit_d;
            fwd_val_q  <= fwd_val_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: data and address are forced to zero outside DRAIN so the
    // unreset read register never reaches the pins.
    // -------------------------------------------------------------------------
    assign veri_al_o        = (state_q == S_ACCUM);
    assign veri_gonder_o    = (state_q == S_DRAIN);
    assign islem_bitti_o    = (state_q == S_DONE);
    assign veri_histogram_o = (state_q == S_DRAIN) ? rd_data_q : '0;
    assign adres_o          = (state_q == S_DRAIN) ? bin_idx_q : 8'd0;

endmodule

// File: tb/tb_histogram_hesapla.sv
// -----------------------------------------------------------------------------
// tb_histogram_hesapla
//
// Four histogram_hesapla instances with different frame sizes share the pixel,
// handshake and reset inputs; each has its own start line, so only the
// selected one runs a frame while the rest sit in IDLE/DONE. A software
// histogram is built as pixels are accepted, pushed as 256 expected words, and
// popped against every drained word.
//   dut 0: PIXELS=16   dut 1: PIXELS=256   dut 2: PIXELS=8   dut 3: PIXELS=76800
// -----------------------------------------------------------------------------
module tb_histogram_hesapla;

    typedef struct packed {
        logic [7:0]  adr;
        logic [31:0] cnt;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [3:0]  basla;
    logic [7:0]  veri;
    logic        gecerli;
    logic        alindi;

    logic [3:0]  al;
    logic [3:0]  gonder;
    logic [3:0]  bitti;
    logic [31:0] hist [4];
    logic [7:0]  adr  [4];

    logic [1:0]  sel;
    logic        s_al, s_gonder, s_bitti;
    logic [31:0] s_hist;
    logic [7:0]  s_adr;

    int          n_assert;
    int          n_fail;
    int          exp_hist [256];
    logic [7:0]  pix_q [$];
    exp_t        exp_q [$];

    always #5 clk_i = ~clk_i;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int unsigned P_G = (g == 0) ? 16 : (g == 1) ? 256 : (g == 2) ? 8 : 76800;
        histogram_hesapla #(
            .PIXELS (P_G),
            .V      (32)
        ) dut (
            .clk_i            (clk_i),
            .rst_i            (rst_i),
            .basla_i          (basla[g]),
            .veri_i           (veri),
            .veri_gecerli_i   (gecerli),
            .veri_al_o        (al[g]),
            .veri_histogram_o (hist[g]),
            .adres_o          (adr[g]),
            .veri_gonder_o    (gonder[g]),
            .veri_alindi_i    (alindi),
            .islem_bitti_o    (bitti[g])
        );
    end

    always_comb begin
        s_al     = al[sel];
        s_gonder = gonder[sel];
        s_bitti  = bitti[sel];
        s_hist   = hist[sel];
        s_adr    = adr[sel];
    end

    // -------------------------------------------------------------------------
    // Scenario building blocks
    // -------------------------------------------------------------------------

    // Pulse start on dut d; optionally check that ready rises in cycle 257.
    task automatic start_frame(input logic [1:0] d, input bit check_timing);
        int c;
        sel = d;
        for (int b = 0; b < 256; b++) exp_hist[b] = 0;
        exp_q.delete();
        @(negedge clk_i);
        basla[d] = 1'b1;
        @(negedge clk_i);
        basla[d] = 1'b0;
        c = 1;
        while (!s_al && c < 400) begin
            @(negedge clk_i);
            c++;
        end
        if (check_timing) begin
            n_assert++;
            if (c !== 257) begin
                n_fail++;
                $display("FAIL clear_latency: ready in cycle %0d, expected 257", c);
            end
        end else if (!s_al) begin
            n_assert++;
            n_fail++;
            $display("FAIL start_timeout: ready never rose, expected 1");
        end
    endtask

    // Offer pixels from pix_q (gap_pct percent idle cycles) until the queue is
    // empty or max_n have been accepted. Leaves us at the negedge after the
    // last accepted pixel.
    task automatic feed(input int gap_pct, input int max_n);
        int acc;
        int guard;
        acc   = 0;
        guard = 0;
        while (pix_q.size() > 0 && acc < max_n && guard < 200000) begin
            if (s_al && ($urandom_range(99) >= gap_pct)) begin
                veri    = pix_q.pop_front();
                gecerli = 1'b1;
                exp_hist[veri]++;
                acc++;
            end else begin
                veri    = 8'($urandom);
                gecerli = 1'b0;
            end
            @(negedge clk_i);
            guard++;
        end
        if (acc < max_n && pix_q.size() > 0) begin
            n_assert++;
            n_fail++;
            $display("FAIL feed_timeout: accepted %0d, expected %0d", acc, max_n);
        end
        for (int b = 0; b < 256; b++) exp_q.push_back('{adr: 8'(b), cnt: 32'(exp_hist[b])});
    endtask

    // After the last pixel: ready must drop next cycle, extra pixels are
    // refused, and the first word appears three cycles after the last accept.
    task automatic post_feed;
        int c;
        veri    = 8'h5A;
        gecerli = 1'b1;
        n_assert++;
        if (s_al !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_drop: veri_al_o=%b, expected 0", s_al);
        end
        c = 1;
        while (!s_gonder && c < 20) begin
            @(negedge clk_i);
            c++;
        end
        gecerli = 1'b0;
        n_assert++;
        if (c !== 3) begin
            n_fail++;
            $display("FAIL flush_latency: first word in cycle t+%0d, expected t+3", c);
        end
    endtask

    // Drain 256 words, popping expected entries on every transfer.
    // mode 0: always ready; mode 1: ready one cycle in three.
    // A start pulse is driven at drain cycle basla_at (negative: none).
    task automatic drain(input int mode, input int basla_at, input int total);
        exp_t        e;
        int          words, cyc, sum;
        bit          prev_stall;
        logic [31:0] prev_hist;
        logic [7:0]  prev_adr;
        words      = 0;
        cyc        = 0;
        sum        = 0;
        prev_stall = 1'b0;
        prev_hist  = '0;
        prev_adr   = '0;
        while (words < 256 && cyc < 5000) begin
            if (s_gonder) begin
                if (prev_stall) begin
                    n_assert++;
                    if (s_hist !== prev_hist || s_adr !== prev_adr) begin
                        n_fail++;
                        $display("FAIL stall_stable: adr %0d cnt %0d, expected adr %0d cnt %0d",
                                 s_adr, s_hist, prev_adr, prev_hist);
                    end
                end
                alindi = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
                if (alindi) begin
                    e = (exp_q.size() > 0) ? exp_q.pop_front() : '{adr: 8'h00, cnt: 32'hFFFF_FFFF};
                    n_assert++;
                    if (s_adr !== e.adr) begin
                        n_fail++;
                        $display("FAIL word_adr: adres_o=%0d, expected %0d", s_adr, e.adr);
                    end
                    n_assert++;
                    if (s_hist !== e.cnt) begin
                        n_fail++;
                        $display("FAIL word_cnt[%0d]: got %0d, expected %0d", e.adr, s_hist, e.cnt);
                    end
                    sum += int'(s_hist);
                    words++;
                end
                prev_stall = !alindi;
                prev_hist  = s_hist;
                prev_adr   = s_adr;
            end else begin
                alindi     = 1'($urandom_range(1));
                prev_stall = 1'b0;
            end
            basla[sel] = (cyc == basla_at);
            @(negedge clk_i);
            cyc++;
        end
        alindi = 1'b0;
        basla  = '0;
        n_assert++;
        if (words !== 256) begin
            n_fail++;
            $display("FAIL drain_words: %0d words, expected 256", words);
        end
        n_assert++;
        if (sum !== total) begin
            n_fail++;
            $display("FAIL drain_sum: %0d, expected %0d", sum, total);
        end
        n_assert++;
        if (s_bitti !== 1'b1 || s_gonder !== 1'b0) begin
            n_fail++;
            $display("FAIL done_flag: bitti=%b gonder=%b, expected 1/0", s_bitti, s_gonder);
        end
    endtask

    // -------------------------------------------------------------------------
    // Scenarios
    // -------------------------------------------------------------------------
    task automatic test_reset;
        rst_i = 1'b0;
        repeat (2) @(negedge clk_i);
        for (int d = 0; d < 4; d++) begin
            n_assert++;
            if ({al[d], gonder[d], bitti[d]} !== 3'b000 || hist[d] !== 32'd0 || adr[d] !== 8'd0) begin
                n_fail++;
                $display("FAIL reset_outputs[%0d]: al/gonder/bitti=%b%b%b hist=%0h adr=%0h, expected all 0",
                         d, al[d], gonder[d], bitti[d], hist[d], adr[d]);
            end
        end
        rst_i = 1'b1;
        repeat (3) @(negedge clk_i);
        for (int d = 0; d < 4; d++) begin
            n_assert++;
            if ({al[d], gonder[d], bitti[d]} !== 3'b000 || hist[d] !== 32'd0 || adr[d] !== 8'd0) begin
                n_fail++;
                $display("FAIL idle_outputs[%0d]: al/gonder/bitti=%b%b%b hist=%0h adr=%0h, expected all 0",
                         d, al[d], gonder[d], bitti[d], hist[d], adr[d]);
            end
        end
    endtask

    task automatic test_zeros;
        start_frame(2'd0, 1'b1);
        for (int i = 0; i < 16; i++) pix_q.push_back(8'h00);
        feed(0, 16);
        post_feed();
        drain(0, -1, 16);
    endtask

    task automatic test_ascending;
        start_frame(2'd1, 1'b0);
        for (int i = 0; i < 256; i++) pix_q.push_back(8'(i));
        feed(30, 256);
        post_feed();
        drain(0, -1, 256);
    endtask

    task automatic test_forwarding;
        logic [7:0] a, b;
        a = 8'h10;
        b = 8'h11;
        start_frame(2'd2, 1'b0);
        pix_q = '{a, a, b, a, b, b, a, a};
        feed(0, 8);
        post_feed();
        drain(0, -1, 8);
    endtask

    task automatic test_backpressure;
        start_frame(2'd0, 1'b0);
        for (int i = 0; i < 16; i++) pix_q.push_back(8'($urandom_range(3)));
        feed(20, 16);
        post_feed();
        drain(1, -1, 16);
    endtask

    task automatic test_reset_mid_accum;
        start_frame(2'd0, 1'b0);
        for (int i = 0; i < 16; i++) pix_q.push_back(8'h33);
        feed(0, 8);
        pix_q.delete();
        rst_i   = 1'b0;
        gecerli = 1'b0;
        #1;
        for (int d = 0; d < 4; d++) begin
            n_assert++;
            if ({al[d], gonder[d], bitti[d]} !== 3'b000 || hist[d] !== 32'd0 || adr[d] !== 8'd0) begin
                n_fail++;
                $display("FAIL midreset_outputs[%0d]: al/gonder/bitti=%b%b%b hist=%0h adr=%0h, expected all 0",
                         d, al[d], gonder[d], bitti[d], hist[d], adr[d]);
            end
        end
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        start_frame(2'd0, 1'b0);
        for (int i = 0; i < 16; i++) pix_q.push_back(8'hFF);
        feed(0, 16);
        post_feed();
        drain(0, -1, 16);
    endtask

    task automatic test_full_frame;
        start_frame(2'd3, 1'b0);
        for (int i = 0; i < 76800; i++) pix_q.push_back(8'(i % 256));
        feed(0, 76800);
        post_feed();
        drain(0, 100, 76800);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst_i    = 1'b0;
        basla    = '0;
        veri     = '0;
        gecerli  = 1'b0;
        alindi   = 1'b0;
        sel      = 2'd0;

        test_reset();
        test_zeros();
        test_ascending();
        test_forwarding();
        test_backpressure();
        test_reset_mid_accum();
        test_full_frame();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/histogram_hesapla.md
# histogram_hesapla

Histogram computation stage in front of the histogram-equalization block. Streams 8-bit grayscale pixels, accumulates a 256-bin count table in an internal synchronous-read memory, then drains the table bin 0..255 as 32-bit words over a valid/ready handshake. The drained words are the histogram-table entries the equalization stage loads into its histogram RAM. Replaces the precomputed histogram file, so the table always matches the image actually streamed.

## Interface

Parameters:
- PIXELS, 76800: pixels per frame (320x240); must satisfy 1 ≤ PIXELS < 2^V.
- V, 32: bin count width.

Ports:
- clk_i  in  1  single clock, all logic on rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- basla_i  in  1  start pulse; honoured only in IDLE or DONE.
- veri_i  in  8  pixel value (bin index).
- veri_gecerli_i  in  1  pixel valid.
- veri_al_o  out  1  ready to accept a pixel; a pixel transfers when veri_gecerli_i && veri_al_o.
- veri_histogram_o  out  V  bin count being offered.
- adres_o  out  8  bin index of veri_histogram_o.
- veri_gonder_o  out  1  output valid.
- veri_alindi_i  in  1  consumer ready; a word transfers when veri_gonder_o && veri_alindi_i.
- islem_bitti_o  out  1  frame complete, table fully drained.

## Operation

- States: IDLE → CLEAR → ACCUM → FLUSH → DRAIN → DONE; DONE → CLEAR on basla_i.
- IDLE: all outputs 0; waits for basla_i.
- CLEAR: writes 0 to bins 0..255, one per cycle, 256 cycles; veri_al_o = 0.
- ACCUM: veri_al_o = 1. Accepted pixel p: cycle t issues read of bin p; cycle t+1 writes read value + 1. Pixel counter increments per transfer. Gaps in veri_gecerli_i are allowed and do not disturb counts.
- Hazard: if the pixel in the write stage has the same bin as the one being read, the read result is replaced by the in-flight written value (forwarding). Back-to-back identical pixels must count correctly at one pixel/cycle.
- Count arithmetic: V-bit unsigned, saturating at 2^V-1 (unreachable under the PIXELS constraint; kept as a guard).
- On the PIXELS-th transfer, veri_al_o drops the following cycle; extra valid pixels are not accepted. FLUSH waits for the pipeline's last write to commit, then enters DRAIN.
- DRAIN: reads bin k, presents the count on veri_histogram_o with adres_o = k and veri_gonder_o = 1. Data and address are held stable while veri_alindi_i = 0. After the transfer of bin 255, enters DONE.
- DONE: islem_bitti_o = 1, veri_gonder_o = 0; holds until basla_i or reset.
- basla_i outside IDLE/DONE is ignored.
- Reset (any state, including mid-ACCUM or mid-DRAIN): immediate return to IDLE, all outputs 0, counters 0. Memory contents are don't-care because every start runs CLEAR.

## Timing

- Reset values: veri_al_o = 0, veri_gonder_o = 0, islem_bitti_o = 0, veri_histogram_o = 0, adres_o = 0.
- basla_i at cycle 0: CLEAR occupies cycles 1..256; veri_al_o = 1 from cycle 257.
- Throughput: 1 pixel/cycle in ACCUM.
- Last pixel accepted at cycle t: FLUSH completes at t+2; first veri_gonder_o = 1 at t+3.
- DRAIN: 1 word/cycle with veri_alindi_i held high. A stall of n cycles adds exactly n cycles. Minimum 256 cycles.
- islem_bitti_o rises 1 cycle after the bin-255 transfer.

## Test plan

- PIXELS=16, 16 pixels of value 0x00 back-to-back, veri_alindi_i = 1 → bin 0 = 16, bins 1..255 = 0; islem_bitti_o after 256 output words.
- PIXELS=256, pixels 0..255 ascending with random valid gaps → every bin = 1, adres_o sequence 0..255.
- PIXELS=8, stream A,A,B,A,B,B,A,A (A=0x10, B=0x11) with no gaps (forwarding stress) → bin 0x10 = 5, bin 0x11 = 3.
- Drain backpressure: veri_alindi_i toggling 1-in-3 → data and address stable while low, no word lost or duplicated, totals sum to PIXELS.
- rst_i asserted low mid-ACCUM, then released; basla_i; full frame of 0xFF → all outputs 0 during reset, final bin 255 = PIXELS, no residue from the aborted frame.
- Full-size PIXELS=76800 frame with 300 pixels of each value 0..255 → every bin = 300; basla_i pulse during DRAIN has no effect.
